// File: rtl/muldiv_ab_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ab_ctrl
//   Multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions.
//   Operands are latched from A and B on an accepted start. The block then
//   runs DATA_WIDTH iterations of either a shift-add multiply or a restoring
//   divide. It finishes with a one-cycle DONE state that pulses the A/B SFR
//   write strobes and the PSW write strobe (OV value, CY cleared).
//
// Ports
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   start   in   one-cycle request, sampled only in IDLE
//   op      in   0 = MUL AB, 1 = DIV AB (sampled with start)
//   a_in    in   A SFR value (sampled with start)
//   b_in    in   B SFR value (sampled with start)
//   busy    out  high from the cycle after an accepted start through DONE
//   done    out  one-cycle completion pulse
//   a_out   out  MUL low byte / DIV quotient
//   b_out   out  MUL high byte / DIV remainder
//   wr_a    out  A write strobe (DONE cycle only, suppressed on DIV by zero)
//   wr_b    out  B write strobe (DONE cycle only, suppressed on DIV by zero)
//   ov      out  PSW OV value, valid while psw_wr is high
//   psw_wr  out  PSW write strobe (OV written, CY cleared), equal to done
// ---------------------------------------------------------------------------
module muldiv_ab_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter bit FAST_DIV0  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  wr_a,
    output logic                  wr_b,
    output logic                  ov,
    output logic                  psw_wr
);

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             op_reg;
    logic             div0_reg;
    // MUL: multiplicand (A). DIV: divisor (B).
    logic [DW-1:0]    operand_reg;
    // Shared datapath: hi holds the upper product half / partial remainder
    // (one extra bit for the add carry or the shifted-in remainder bit),
    // lo holds the multiplier being consumed / dividend becoming quotient.
    logic [DW:0]      hi_reg;
    logic [DW-1:0]    lo_reg;

    logic             busy_reg, done_reg, wr_a_reg, wr_b_reg, ov_reg, psw_wr_reg;
    logic [DW-1:0]    a_out_reg, b_out_reg;

    logic [DW:0]      hi_next;
    logic [DW-1:0]    lo_next;
    logic [DW:0]      sum;
    logic [DW:0]      shifted;
    logic [DW:0]      divisor_ext;

    // One iteration of the selected algorithm.
    always_comb begin
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        divisor_ext = {1'b0, operand_reg};
        sum         = {1'b0, hi_reg[DW-1:0]} + (lo_reg[0] ? divisor_ext : '0);
        shifted     = {hi_reg[DW-1:0], lo_reg[DW-1]};
        if (op_reg) begin
            // Restoring divide, quotient bits enter at the LSB of lo.
            if (shifted >= divisor_ext) begin
                hi_next = shifted - divisor_ext;
                lo_next = {lo_reg[DW-2:0], 1'b1};
            end else begin
                hi_next = shifted;
                lo_next = {lo_reg[DW-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: {carry, hi, lo} shifts right by one.
            hi_next = {1'b0, sum[DW:1]};
            lo_next = {sum[0], lo_reg[DW-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= 1'b0;
            div0_reg    <= 1'b0;
            operand_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wr_a_reg    <= 1'b0;
            wr_b_reg    <= 1'b0;
            ov_reg      <= 1'b0;
            psw_wr_reg  <= 1'b0;
            a_out_reg   <= '0;
            b_out_reg   <= '0;
        end else begin
            done_reg   <= 1'b0;
            wr_a_reg   <= 1'b0;
            wr_b_reg   <= 1'b0;
            psw_wr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg      <= op;
                        div0_reg    <= op && (b_in == '0);
                        operand_reg <= op ? b_in : a_in;
                        lo_reg      <= op ? a_in : b_in;
                        hi_reg      <= '0;
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b1;
                        if (FAST_DIV0 && op && (b_in == '0)) begin
                            // Nothing to compute: report OV and leave A/B alone.
                            state_reg  <= DONE_ST;
                            done_reg   <= 1'b1;
                            psw_wr_reg <= 1'b1;
                            ov_reg     <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg  <= DONE_ST;
                        done_reg   <= 1'b1;
                        psw_wr_reg <= 1'b1;
                        if (div0_reg) begin
                            ov_reg <= 1'b1;
                        end else begin
                            ov_reg    <= op_reg ? 1'b0 : (hi_next[DW-1:0] != '0);
                            a_out_reg <= lo_next;
                            b_out_reg <= hi_next[DW-1:0];
                            wr_a_reg  <= 1'b1;
                            wr_b_reg  <= 1'b1;
                        end
                    end
                end
                DONE_ST: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign a_out  = a_out_reg;
    assign b_out  = b_out_reg;
    assign wr_a   = wr_a_reg;
    assign wr_b   = wr_b_reg;
    assign ov     = ov_reg;
    assign psw_wr = psw_wr_reg;

endmodule

// File: tb/tb_muldiv_ab_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ab_ctrl
//   Two instances share all inputs: one with FAST_DIV0 = 1 (suffix _f) and
//   one with FAST_DIV0 = 0 (suffix _s). Expected results come from plain
//   arithmetic on the operands (a*b, a/b, a%b) plus the remembered last
//   written A/B values for the divide-by-zero case.
// ---------------------------------------------------------------------------
module tb_muldiv_ab_ctrl;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op    = 1'b0;
    logic [DW-1:0] a_in  = '0;
    logic [DW-1:0] b_in  = '0;

    logic          busy_f, done_f, wr_a_f, wr_b_f, ov_f, psw_wr_f;
    logic [DW-1:0] a_out_f, b_out_f;
    logic          busy_s, done_s, wr_a_s, wr_b_s, ov_s, psw_wr_s;
    logic [DW-1:0] a_out_s, b_out_s;

    int tests = 0;
    int fails = 0;

    // Last values actually written to A/B (identical for both instances).
    logic [DW-1:0] prev_a = '0;
    logic [DW-1:0] prev_b = '0;

    always #5 clock = ~clock;

    muldiv_ab_ctrl #(.DATA_WIDTH(DW), .FAST_DIV0(1'b1)) dut_fast (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in),
        .busy(busy_f), .done(done_f), .a_out(a_out_f), .b_out(b_out_f),
        .wr_a(wr_a_f), .wr_b(wr_b_f), .ov(ov_f), .psw_wr(psw_wr_f)
    );

    muldiv_ab_ctrl #(.DATA_WIDTH(DW), .FAST_DIV0(1'b0)) dut_slow (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in),
        .busy(busy_s), .done(done_s), .a_out(a_out_s), .b_out(b_out_s),
        .wr_a(wr_a_s), .wr_b(wr_b_s), .ov(ov_s), .psw_wr(psw_wr_s)
    );

    // mode 0: plain run; 1: new start + operand changes at E3;
    // 2: start asserted during the DONE cycle.
    task automatic do_op(input logic o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int mode);
        logic [2*DW-1:0] prod;
        logic [DW-1:0]   ea, eb;
        logic            eov, ewr;
        int              lat [2];
        int              npulse [2];
        logic            d_busy, d_done, d_wra, d_wrb, d_ov, d_psw;
        logic [DW-1:0]   d_a, d_b;
        if (!o) begin
            prod = 16'(a) * 16'(b);
            ea = prod[DW-1:0]; eb = prod[2*DW-1:DW]; eov = (eb != 0); ewr = 1'b1;
        end else if (b == 0) begin
            ea = prev_a; eb = prev_b; eov = 1'b1; ewr = 1'b0;
        end else begin
            ea = a / b; eb = a % b; eov = 1'b0; ewr = 1'b1;
        end
        lat[0] = (o && b == 0) ? 0 : DW;
        lat[1] = DW;
        npulse[0] = 0;
        npulse[1] = 0;

        @(posedge clock); #1;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock); #1;              // E0 has just happened
        start = 1'b0;
        op    = $urandom_range(0, 1);
        a_in  = DW'($urandom);
        b_in  = DW'($urandom);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            for (int d = 0; d < 2; d++) begin
                d_busy = d ? busy_s  : busy_f;   d_done = d ? done_s   : done_f;
                d_wra  = d ? wr_a_s  : wr_a_f;   d_wrb  = d ? wr_b_s   : wr_b_f;
                d_ov   = d ? ov_s    : ov_f;     d_psw  = d ? psw_wr_s : psw_wr_f;
                d_a    = d ? a_out_s : a_out_f;  d_b    = d ? b_out_s  : b_out_f;
                tests++;
                if (d_psw !== d_done) begin
                    fails++;
                    $display("FAIL psw_wr_eq_done dut=%0d k=%0d psw_wr=%b done=%b", d, k, d_psw, d_done);
                end
                if (k <= lat[d]) begin
                    tests++;
                    if (d_busy !== 1'b1) begin
                        fails++;
                        $display("FAIL busy_high dut=%0d k=%0d got=%b want=1", d, k, d_busy);
                    end
                end else if (k == lat[d] + 1) begin
                    tests++;
                    if (d_busy !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_low dut=%0d k=%0d got=%b want=0", d, k, d_busy);
                    end
                end
                if (d_done === 1'b1) begin
                    npulse[d]++;
                    tests++;
                    if (k != lat[d]) begin
                        fails++;
                        $display("FAIL done_latency dut=%0d got=%0d want=%0d", d, k, lat[d]);
                    end
                    tests++;
                    if (d_a !== ea || d_b !== eb || d_ov !== eov) begin
                        fails++;
                        $display("FAIL result dut=%0d op=%0d a=%h b=%h got A=%h B=%h ov=%b want A=%h B=%h ov=%b",
                                 d, o, a, b, d_a, d_b, d_ov, ea, eb, eov);
                    end
                    tests++;
                    if (d_wra !== ewr || d_wrb !== ewr) begin
                        fails++;
                        $display("FAIL write_strobes dut=%0d got wr_a=%b wr_b=%b want %b", d, d_wra, d_wrb, ewr);
                    end
                end else begin
                    tests++;
                    if (d_wra !== 1'b0 || d_wrb !== 1'b0) begin
                        fails++;
                        $display("FAIL stray_strobe dut=%0d k=%0d wr_a=%b wr_b=%b want 0", d, k, d_wra, d_wrb);
                    end
                end
            end
            if (mode == 1 && k == 3) begin
                start = 1'b1; op = ~o; a_in = DW'($urandom); b_in = DW'($urandom_range(1, 255));
            end
            if (mode == 1 && k == 4) start = 1'b0;
            if (mode == 2 && k == DW) begin
                start = 1'b1; op = 1'b0; a_in = DW'($urandom); b_in = DW'($urandom);
            end
            if (mode == 2 && k == DW + 1) start = 1'b0;
            if (mode == 2 && k == DW + 2) begin
                tests++;
                if (busy_f !== 1'b0 || busy_s !== 1'b0) begin
                    fails++;
                    $display("FAIL start_in_done_ignored busy_f=%b busy_s=%b want 0", busy_f, busy_s);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (npulse[d] != 1) begin
                fails++;
                $display("FAIL done_pulse_count dut=%0d got=%0d want=1", d, npulse[d]);
            end
        end
        if (ewr) begin
            prev_a = ea;
            prev_b = eb;
        end
        $display("[TB] op=%0d a=%h b=%h -> A=%h B=%h ov=%b wr=%b", o, a, b, ea, eb, eov, ewr);
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({busy_f, done_f, wr_a_f, wr_b_f, ov_f, psw_wr_f, a_out_f, b_out_f} !== '0 ||
            {busy_s, done_s, wr_a_s, wr_b_s, ov_s, psw_wr_s, a_out_s, b_out_s} !== '0) begin
            fails++;
            $display("FAIL reset_state fast=%b%b%b%b%b%b %h %h want all zero",
                     busy_f, done_f, wr_a_f, wr_b_f, ov_f, psw_wr_f, a_out_f, b_out_f);
        end
        @(negedge clock);
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_mul();
        do_op(1'b0, 8'h50, 8'hA0, 0);
        do_op(1'b0, 8'h0C, 8'h0A, 0);
        do_op(1'b0, 8'hFF, 8'hFF, 0);
        do_op(1'b0, 8'h00, 8'hFF, 0);
    endtask

    task automatic test_div();
        do_op(1'b1, 8'hFB, 8'h12, 0);
        do_op(1'b1, 8'h07, 8'h01, 0);
        do_op(1'b1, 8'h00, 8'h5A, 0);
        do_op(1'b1, 8'hFF, 8'hFF, 0);
    endtask

    task automatic test_div0();
        do_op(1'b1, 8'h33, 8'h00, 0);
        do_op(1'b1, 8'h00, 8'h00, 0);
    endtask

    task automatic test_random();
        logic          o;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = $urandom_range(0, 1);
            a = ($urandom_range(0, 9) == 0) ? 8'hFF : DW'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
            do_op(o, a, b, 0);
        end
    endtask

    task automatic test_busy_ignore();
        do_op(1'b0, 8'hA7, 8'h3C, 1);
        do_op(1'b1, 8'hC9, 8'h0B, 1);
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 8'h12, 8'h34, 2);
        do_op(1'b0, 8'h56, 8'h78, 0);
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        start = 1'b1; op = 1'b1; a_in = 8'hFB; b_in = 8'h12;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy_f, done_f, wr_a_f, wr_b_f, psw_wr_f, a_out_f, b_out_f} !== '0 ||
            {busy_s, done_s, wr_a_s, wr_b_s, psw_wr_s, a_out_s, b_out_s} !== '0) begin
            fails++;
            $display("FAIL reset_mid_clear busy=%b/%b done=%b/%b A=%h/%h B=%h/%h want 0",
                     busy_f, busy_s, done_f, done_s, a_out_f, a_out_s, b_out_f, b_out_s);
        end
        @(negedge clock);
        reset = 1'b0;
        prev_a = '0;
        prev_b = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            tests++;
            if (done_f !== 1'b0 || done_s !== 1'b0 || wr_a_f !== 1'b0 || wr_a_s !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_no_done k=%0d done=%b/%b wr_a=%b/%b want 0",
                         k, done_f, done_s, wr_a_f, wr_a_s);
            end
        end
        $display("[TB] reset mid-operation checked");
        do_op(1'b1, 8'hFB, 8'h12, 0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
